fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the single-cycle RISC-V core, directly upstream of the control unit and datapath. Holds the program counter, issues one request at a time to a variable-latency instruction memory, and presents the fetched instruction with its PC until the core signals completion. On completion it computes the next PC from the control unit's `PCSrc` selection (sequential, branch/JAL target, or JALR target) and starts the next fetch.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, input, 1: clock; all state updates on the rising edge.
  - `rst`, input, 1: synchronous, active-high reset.
- Next-PC selection:
  - `PCSrc`, input, 2: next-PC select, from the control unit.
  - `PCTarget`, input, 32: PC+ImmExt, the branch and JAL target.
  - `ALUResult`, input, 32: JALR target.
- Core handshake:
  - `retire`, input, 1: the core has finished the presented instruction; sampled only in HOLD.
- Instruction memory:
  - `imem_req`, output, 1: fetch request valid.
  - `imem_addr`, output, 32: fetch address, always equal to `PC`.
  - `imem_ready`, input, 1: memory accepts the request this cycle.
  - `imem_rvalid`, input, 1: read data valid.
  - `imem_rdata`, input, 32: instruction word.
- Outputs to the core:
  - `Instr`, output, 32: registered instruction, to the decoder.
  - `PC`, output, 32: address of `Instr`.
  - `PCPlus4`, output, 32: `PC + 4`, combinational.
  - `instr_valid`, output, 1: `Instr` and `PC` are valid and the core may execute.
  - `misalign_err`, output, 1: sticky misaligned-target flag.

## Operation

- FSM has four states: FETCH, WAIT, HOLD, HALT.
  - FETCH: `imem_req`=1. If `imem_ready`=1, go to WAIT; otherwise stay and hold `imem_addr` stable.
  - WAIT: `imem_req`=0. On `imem_rvalid`=1, `Instr`<=`imem_rdata`, `instr_valid`<=1, go to HOLD.
  - HOLD: `instr_valid`=1. On `retire`=1, `PC`<=PCNext, `instr_valid`<=0, go to FETCH.
  - HALT: entered only on a misaligned target (see Configuration). `imem_req`=0 and `instr_valid`=0. Left only by `rst`.
- PCNext is selected by `PCSrc`:
  - 2'b00: `PC`+4.
  - 2'b01: `PCTarget`.
  - 2'b10: `ALUResult`.
  - 2'b11: `PC`+4, reserved.
- All additions are modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- `imem_rvalid` is ignored in FETCH, HOLD, and HALT.
- `retire` is ignored outside HOLD.
- Only one request is outstanding at a time. The instruction memory shares `rst`, so no response survives a reset.

## Timing

- Reset values:
  - `PC`=`RESET_PC`, `Instr`=32'h0000_0013 (NOP), `instr_valid`=0, `misalign_err`=0.
  - State is FETCH, so `imem_req`=1 on the first cycle after `rst` deasserts.
  - During the reset cycle itself, `imem_req`=0.
- Best case per instruction is 3 cycles: FETCH accepted, then `rvalid` in the next cycle, then `retire` in the first HOLD cycle.
- `instr_valid` rises the cycle after `imem_rvalid`. It falls the cycle after `retire`.
- `PC` changes only on the edge that consumes `retire`, or on reset.
- `PCSrc`, `PCTarget`, and `ALUResult` are sampled only on that edge.
- `rst` wins over every other event in the same cycle, in every state, including mid-WAIT. No partial update is allowed.

## Configuration

- Macro: `FETCH_MISALIGN_TRAP_EN`.
- Defined:
  - If PCNext[1:0]≠0 when `retire` is consumed, `PC` is not updated, `misalign_err`<=1, and the FSM goes to HALT.
  - `misalign_err` stays 1 until reset.
- Undefined:
  - PCNext[1:0] is forced to 2'b00 before loading `PC`.
  - `misalign_err` is tied to 0 and HALT is unreachable.

## Test plan

- Reset, then memory with `imem_ready`=1 and 1-cycle `rvalid`, `PCSrc`=00, `retire` asserted in HOLD -> `imem_addr` sequence 0x0, 0x4, 0x8 with 3 cycles per instruction; `Instr` matches memory words.
- `imem_ready` low for 3 cycles in FETCH, then `rvalid` 4 cycles after accept -> `imem_addr` stable throughout; `instr_valid` rises exactly one cycle after `rvalid`; `PC` unchanged.
- `PCSrc`=01 with `PCTarget`=0x100, then `PCSrc`=10 with `ALUResult`=0x2C -> next fetches at 0x100 then 0x2C; `PC`=0xFFFF_FFFC with `PCSrc`=00 -> next fetch at 0x0.
- `rst` asserted in WAIT while `rvalid` arrives in the same cycle -> `Instr`=0x00000013, `instr_valid`=0, `PC`=`RESET_PC`; fetch restarts at `RESET_PC`.
- `retire` held high continuously, plus spurious `rvalid` in HOLD -> exactly one `PC` advance per HOLD visit; `Instr` is not overwritten.
- `ALUResult`=0x2E with `PCSrc`=10 -> with macro: `misalign_err`=1, `imem_req` stays 0, `PC` unchanged. Without macro: next fetch at 0x2C and `misalign_err`=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one request at a time to instruction memory and
// presents the fetched word until retire. Optional trap on misaligned targets: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  output logic        misalign_err
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StFetch, StWait, StHold, StHalt} state_e;

  state_e      state;
  logic [31:0] pc_next;
  logic [31:0] pc_next_aligned;

  assign PCPlus4   = PC + 32'd4;
  assign imem_addr = PC;
  // Decoded from state but held low while reset is asserted.
  assign imem_req  = (state == StFetch) && !rst;

  always_comb begin
    case (PCSrc)
      2'b01:   pc_next = PCTarget;
      2'b10:   pc_next = ALUResult;
      default: pc_next = PCPlus4;
    endcase
  end

  assign pc_next_aligned = pc_next & ~32'd3;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StFetch;
      PC          <= RESET_PC;
      Instr       <= Nop;
      instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      case (state)
        StFetch: begin
          if (imem_ready) state <= StWait;
        end
        StWait: begin
          if (imem_rvalid) begin
            Instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= StHold;
          end
        end
        StHold: begin
          if (retire) begin
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (pc_next[1:0] != 2'b00) begin
              misalign_q <= 1'b1;
              state      <= StHalt;
            end else begin
              PC    <= pc_next;
              state <= StFetch;
            end
`else
            PC    <= pc_next_aligned;
            state <= StFetch;
`endif
          end
        end
        default: begin
          // Halted until reset.
          state       <= StHalt;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed steps plus randomized instructions against a
// next-PC reference model and an address-hashed memory image.
module tb_fetch_unit;

  localparam logic [31:0] RstPc = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [1:0]  pc_src;
  logic [31:0] pc_target;
  logic [31:0] alu_result;
  logic        retire;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        misalign_err;

  fetch_unit #(.RESET_PC(RstPc)) dut (
    .clk         (clk),
    .rst         (rst),
    .PCSrc       (pc_src),
    .PCTarget    (pc_target),
    .ALUResult   (alu_result),
    .retire      (retire),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .Instr       (instr),
    .PC          (pc),
    .PCPlus4     (pc_plus4),
    .instr_valid (instr_valid),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // Architectural next-PC rule: PC+4 unless a target is selected; aligned down without the trap.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [1:0] src,
                                           input logic [31:0] tgt, input logic [31:0] alu);
    logic [31:0] n;
    if (src == 2'd1)      n = tgt;
    else if (src == 2'd2) n = alu;
    else                  n = cur + 32'd4;
`ifndef FETCH_MISALIGN_TRAP_EN
    n = n - (n % 4);
`endif
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, RstPc);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    rst      = 1'b0;
    model_pc = RstPc;
    step();
  endtask

  // Entered at a negedge with the DUT fetching; leaves at a negedge after the retire edge.
  task automatic run_instr(input int rdy_dly, input int rv_dly, input int ret_dly,
                           input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                           input bit hold_retire, input bit spurious);
    logic [31:0] word;
    logic [31:0] nxt;
    word = mem_word(model_pc);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, model_pc);
    chk("fetch_pc4", pc_plus4, model_pc + 32'd4);
    chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ready  = 1'b0;
      imem_rvalid = spurious;
      imem_rdata  = ~word;
      step();
      chk("stall_addr", imem_addr, model_pc);
      chk("stall_req", {31'd0, imem_req}, 32'd1);
    end
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    step();
    imem_ready = 1'b0;
    chk("wait_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < rv_dly; i++) begin
      imem_rvalid = 1'b0;
      step();
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      chk("wait_pc", pc, model_pc);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    step();
    imem_rvalid = 1'b0;
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_instr", instr, word);
    chk("hold_pc", pc, model_pc);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < ret_dly; i++) begin
      retire      = 1'b0;
      imem_rvalid = spurious;
      imem_rdata  = ~word;
      step();
      chk("hold_wait_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_wait_instr", instr, word);
      chk("hold_wait_pc", pc, model_pc);
    end
    retire      = 1'b1;
    pc_src      = src;
    pc_target   = tgt;
    alu_result  = alu;
    imem_rvalid = spurious;
    imem_rdata  = ~word;
    step();
    if (!hold_retire) retire = 1'b0;
    imem_rvalid = 1'b0;
    pc_src      = 2'($urandom);
    pc_target   = $urandom;
    alu_result  = $urandom;
    nxt = ref_next(model_pc, src, tgt, alu);
    chk("ret_valid", {31'd0, instr_valid}, 32'd0);
    chk("ret_instr", instr, word);
`ifdef FETCH_MISALIGN_TRAP_EN
    if (nxt[1:0] != 2'b00) begin
      chk("trap_mis", {31'd0, misalign_err}, 32'd1);
      chk("trap_pc", pc, model_pc);
      for (int i = 0; i < 3; i++) begin
        step();
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_mis", {31'd0, misalign_err}, 32'd1);
      end
      return;
    end
`endif
    model_pc = nxt;
    chk("ret_pc", pc, model_pc);
    chk("ret_req", {31'd0, imem_req}, 32'd1);
    chk("ret_mis", {31'd0, misalign_err}, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    pc_src      = 2'd0;
    pc_target   = 32'd0;
    alu_result  = 32'd0;
    retire      = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    model_pc    = RstPc;
    step();
    do_reset();

    // Best-case sequential stream: 0x0, 0x4, 0x8.
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("seq_pc", pc, 32'h0000_000C);

    // Memory back-pressure and long read latency.
    run_instr(3, 3, 1, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Branch/JAL target, then JALR target, then reserved select.
    run_instr(0, 0, 0, 2'd1, 32'h0000_0100, 32'h0000_0BAD, 1'b0, 1'b0);
    chk("jal_pc", pc, 32'h0000_0100);
    run_instr(1, 0, 0, 2'd2, 32'h0000_0BAD, 32'h0000_002C, 1'b0, 1'b0);
    chk("jalr_pc", pc, 32'h0000_002C);
    run_instr(0, 1, 0, 2'd3, 32'h0000_0BAD, 32'h0000_0BAD, 1'b0, 1'b0);
    chk("rsvd_pc", pc, 32'h0000_0030);

    // Wrap at the top of the address space.
    run_instr(0, 0, 0, 2'd1, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b0);
    run_instr(0, 0, 0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("wrap_pc", pc, 32'h0000_0000);
    run_instr(0, 0, 0, 2'd1, 32'h0000_0200, 32'd0, 1'b0, 1'b0);

    // Reset in WAIT colliding with rvalid.
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    chk("mid_wait_req", {31'd0, imem_req}, 32'd0);
    rst         = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("mid_rst_instr", instr, 32'h0000_0013);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_pc", pc, RstPc);
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    rst      = 1'b0;
    model_pc = RstPc;
    step();
    chk("restart_addr", imem_addr, RstPc);

    // Retire held high throughout, with spurious rvalid in FETCH and HOLD.
    for (int i = 0; i < 3; i++) run_instr(2, 1, 0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    retire = 1'b0;
    chk("held_ret_pc", pc, 32'h0000_000C);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] t;
      logic [31:0] a;
      t = $urandom;
      a = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      t = t & ~32'd3;
      a = a & ~32'd3;
`endif
      run_instr($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2),
                2'($urandom_range(0, 3)), t, a, 1'b0, 1'($urandom_range(0, 1)));
    end

    // Misaligned JALR target; halts with the trap, aligns down without it.
    run_instr(0, 0, 0, 2'd1, 32'h0000_0040, 32'd0, 1'b0, 1'b0);
    run_instr(0, 0, 0, 2'd2, 32'd0, 32'h0000_002E, 1'b0, 1'b0);
`ifndef FETCH_MISALIGN_TRAP_EN
    chk("mis_align_pc", pc, 32'h0000_002C);
    chk("mis_align_addr", imem_addr, 32'h0000_002C);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
